// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: op-code enum and FSM states.
// Imported by alu_op_decode and alu_decode_seq.
package alu_pkg;

  localparam int ALU_CTRL_W = 4;

  typedef enum logic [ALU_CTRL_W-1:0] {
    OP_ADD     = 4'd0,
    OP_SUB     = 4'd1,
    OP_OR      = 4'd2,
    OP_AND     = 4'd3,
    OP_XOR     = 4'd4,
    OP_SLT     = 4'd5,
    OP_SLTU    = 4'd6,
    OP_SLL     = 4'd7,
    OP_SRL     = 4'd8,
    OP_SRA     = 4'd9,
    OP_MUL     = 4'd10,
    OP_ILLEGAL = 4'd15
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_MUL,
    ST_DONE
  } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU control decode from alu_op/opcode/funct3/funct7.
// Ports: opcode, funct3, funct7, alu_op in; alu_control out.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter bit SUPPORT_M = 1'b1
) (
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [1:0]            alu_op,
  output logic [ALU_CTRL_W-1:0] alu_control
);

  logic m_enc;
  logic sub_enc;
  logic unused_opc;

  // Only opcode[5] (register vs immediate form) matters here.
  assign unused_opc = ^{opcode[6], opcode[4:0]};

  assign m_enc   = (alu_op == 2'b10) && opcode[5] &&
                   (funct7 == 7'b0000001);
  assign sub_enc = opcode[5] && funct7[5];

  alu_ctrl_e op;

  always_comb begin
    op = OP_ILLEGAL;
    unique case (1'b1)
      alu_op == 2'b00: op = OP_ADD;
      alu_op == 2'b01: op = OP_SUB;
      alu_op == 2'b11: op = OP_ILLEGAL;
      m_enc: begin
        op = (SUPPORT_M && funct3 == 3'b000)
           ? OP_MUL : OP_ILLEGAL;
      end
      default: begin
        case (funct3)
          3'b000: op = sub_enc ? OP_SUB : OP_ADD;
          3'b001: op = OP_SLL;
          3'b010: op = OP_SLT;
          3'b011: op = OP_SLTU;
          3'b100: op = OP_XOR;
          3'b101: op = funct7[5] ? OP_SRA : OP_SRL;
          3'b110: op = OP_OR;
          default: op = OP_AND;
        endcase
      end
    endcase
  end

  assign alu_control = op;

endmodule

// File: rtl/alu_decode_seq.sv
// Sequential ALU: decodes a request, runs 1-cycle, bit-serial shift or
// shift-add MUL, holds result until out_ready. Ports: valid/ready in/out.
module alu_decode_seq
  import alu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit SUPPORT_M = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [1:0]            alu_op,
  input  logic [XLEN-1:0]       src_a,
  input  logic [XLEN-1:0]       src_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       result,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  illegal
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = SHW + 1;

  logic [ALU_CTRL_W-1:0] dec_ctrl;

  alu_op_decode #(
    .SUPPORT_M (SUPPORT_M)
  ) u_dec (
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7      (funct7),
    .alu_op      (alu_op),
    .alu_control (dec_ctrl)
  );

  state_e          state_q;
  alu_ctrl_e       op_q;
  alu_ctrl_e       ctrl_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] result_q;
  logic [CW-1:0]   cnt_q;
  logic            illegal_q;
  logic            out_valid_q;

  alu_ctrl_e       dec_op;
  logic [SHW-1:0]  shamt;
  logic            is_shift;
  logic [XLEN-1:0] simple_d;
  logic [XLEN-1:0] shift_d;
  logic [XLEN-1:0] acc_d;

  assign dec_op   = alu_ctrl_e'(dec_ctrl);
  assign shamt    = src_b[SHW-1:0];
  assign is_shift = (dec_op == OP_SLL) ||
                    (dec_op == OP_SRL) ||
                    (dec_op == OP_SRA);

  always_comb begin
    simple_d = '0;
    case (dec_op)
      OP_ADD:  simple_d = src_a + src_b;
      OP_SUB:  simple_d = src_a - src_b;
      OP_AND:  simple_d = src_a & src_b;
      OP_OR:   simple_d = src_a | src_b;
      OP_XOR:  simple_d = src_a ^ src_b;
      OP_SLT:  simple_d[0] = $signed(src_a) < $signed(src_b);
      OP_SLTU: simple_d[0] = src_a < src_b;
      default: simple_d = '0;
    endcase
  end

  // One shift step; a_q is the working register in SHIFT.
  always_comb begin
    shift_d = '0;
    case (op_q)
      OP_SLL:  shift_d = a_q << 1;
      OP_SRL:  shift_d = a_q >> 1;
      default: shift_d = {a_q[XLEN-1], a_q[XLEN-1:1]};
    endcase
  end

  // Shift-add: a_q is the shifted multiplicand, b_q the multiplier.
  assign acc_d = acc_q + (b_q[0] ? a_q : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_ADD;
      ctrl_q      <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            op_q      <= dec_op;
            a_q       <= src_a;
            b_q       <= src_b;
            acc_q     <= '0;
            illegal_q <= 1'b0;
            if (is_shift && shamt != '0) begin
              cnt_q   <= {1'b0, shamt};
              state_q <= ST_SHIFT;
            end else if (is_shift) begin
              result_q    <= src_a;
              ctrl_q      <= dec_op;
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end else if (dec_op == OP_MUL) begin
              cnt_q   <= CW'(XLEN);
              state_q <= ST_MUL;
            end else begin
              result_q    <= simple_d;
              ctrl_q      <= dec_op;
              illegal_q   <= (dec_op == OP_ILLEGAL);
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          a_q   <= shift_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_q    <= shift_d;
            ctrl_q      <= op_q;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_MUL: begin
          acc_q <= acc_d;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_q    <= acc_d;
            ctrl_q      <= op_q;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign alu_control = ctrl_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_alu_decode_seq.sv
// Directed vector bench for alu_decode_seq (XLEN=32, M on and off).
module tb_alu_decode_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, nm_in_valid;
  logic        in_ready, nm_in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [1:0]  alu_op;
  logic [31:0] src_a, src_b;
  logic        out_valid, nm_out_valid;
  logic        out_ready, nm_out_ready;
  logic [31:0] result, nm_result;
  logic [3:0]  alu_control, nm_alu_control;
  logic        illegal, nm_illegal;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_decode_seq #(.XLEN(32), .SUPPORT_M(1'b1)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .alu_op(alu_op), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .alu_control(alu_control),
    .illegal(illegal)
  );

  alu_decode_seq #(.XLEN(32), .SUPPORT_M(1'b0)) dut_nm (
    .clk(clk), .reset(reset),
    .in_valid(nm_in_valid), .in_ready(nm_in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .alu_op(alu_op), .src_a(src_a), .src_b(src_b),
    .out_valid(nm_out_valid), .out_ready(nm_out_ready),
    .result(nm_result), .alu_control(nm_alu_control),
    .illegal(nm_illegal)
  );

  typedef struct {
    logic [1:0]  aop;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  ctl;
    logic        ill;
    int          lat;
  } vec_t;

  localparam int NV = 20;
  vec_t vt [NV];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    alu_op = v.aop;
    opcode = v.opc;
    funct3 = v.f3;
    funct7 = v.f7;
    src_a  = v.a;
    src_b  = v.b;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_vec(int i, vec_t v);
    int lat;
    @(negedge clk);
    wait_ready();
    chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'd1);
    drive(v);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk($sformatf("v%0d latency", i), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d result", i), result, v.res);
    chk($sformatf("v%0d ctrl", i), 32'(alu_control), 32'(v.ctl));
    chk($sformatf("v%0d illegal", i), 32'(illegal), 32'(v.ill));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk($sformatf("v%0d ready after", i), 32'(in_ready), 32'd1);
  endtask

  localparam logic [6:0] R = 7'b0110011;
  localparam logic [6:0] I = 7'b0010011;

  initial begin
    vec_t v;
    int   lat;
    logic seen;

    vt[0]  = '{2'b00, R, 3'd0, 7'h00, 32'd5, 32'd7, 32'd12, 4'd0, 1'b0, 1};
    vt[1]  = '{2'b01, R, 3'd0, 7'h00, 32'd5, 32'd7, 32'hFFFFFFFE, 4'd1, 1'b0, 1};
    vt[2]  = '{2'b10, R, 3'd0, 7'h20, 32'd5, 32'd7, 32'hFFFFFFFE, 4'd1, 1'b0, 1};
    vt[3]  = '{2'b10, I, 3'd0, 7'h20, 32'd5, 32'd7, 32'd12, 4'd0, 1'b0, 1};
    vt[4]  = '{2'b10, R, 3'd7, 7'h00, 32'hF0F0F0F0, 32'hFF00FF00,
               32'hF000F000, 4'd3, 1'b0, 1};
    vt[5]  = '{2'b10, R, 3'd6, 7'h00, 32'hF0F0F0F0, 32'h0F000000,
               32'hFFF0F0F0, 4'd2, 1'b0, 1};
    vt[6]  = '{2'b10, R, 3'd4, 7'h00, 32'hFFFF0000, 32'h0F0F0F0F,
               32'hF0F00F0F, 4'd4, 1'b0, 1};
    vt[7]  = '{2'b10, R, 3'd2, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd1, 4'd5, 1'b0, 1};
    vt[8]  = '{2'b10, R, 3'd3, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd0, 4'd6, 1'b0, 1};
    vt[9]  = '{2'b10, R, 3'd1, 7'h00, 32'd1, 32'd31, 32'h80000000, 4'd7, 1'b0, 32};
    vt[10] = '{2'b10, R, 3'd5, 7'h00, 32'h80000000, 32'd4,
               32'h08000000, 4'd8, 1'b0, 5};
    vt[11] = '{2'b10, R, 3'd5, 7'h20, 32'h80000000, 32'd4,
               32'hF8000000, 4'd9, 1'b0, 5};
    vt[12] = '{2'b10, R, 3'd5, 7'h20, 32'h80000000, 32'd0,
               32'h80000000, 4'd9, 1'b0, 1};
    vt[13] = '{2'b10, I, 3'd5, 7'h00, 32'hF0000000, 32'h24,
               32'h0F000000, 4'd8, 1'b0, 5};
    vt[14] = '{2'b10, R, 3'd0, 7'h01, 32'hFFFFFFFF, 32'd3,
               32'hFFFFFFFD, 4'd10, 1'b0, 33};
    vt[15] = '{2'b10, R, 3'd0, 7'h01, 32'd12345, 32'd1000,
               32'h00BC5EA8, 4'd10, 1'b0, 33};
    vt[16] = '{2'b10, R, 3'd1, 7'h01, 32'd6, 32'd7, 32'd0, 4'd15, 1'b1, 1};
    vt[17] = '{2'b11, R, 3'd0, 7'h00, 32'd6, 32'd7, 32'd0, 4'd15, 1'b1, 1};
    vt[18] = '{2'b10, I, 3'd0, 7'h01, 32'd2, 32'd3, 32'd5, 4'd0, 1'b0, 1};
    vt[19] = '{2'b10, R, 3'd5, 7'h20, 32'h40000000, 32'd1,
               32'h20000000, 4'd9, 1'b0, 2};

    reset = 1'b1;
    in_valid = 1'b0;
    nm_in_valid = 1'b0;
    out_ready = 1'b0;
    nm_out_ready = 1'b0;
    drive(vt[0]);
    repeat (3) @(posedge clk);
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst result", result, 32'd0);
    chk("rst ctrl", 32'(alu_control), 32'd0);
    chk("rst illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(i, vt[i]);

    // Back-pressure on SLTU, with a competing request that must be ignored.
    v = '{2'b10, R, 3'd3, 7'h00, 32'd1, 32'hFFFFFFFF, 32'd1, 4'd6, 1'b0, 1};
    @(negedge clk);
    drive(v);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    drive(vt[0]);
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("hold%0d valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("hold%0d result", c), result, 32'd1);
      chk($sformatf("hold%0d ctrl", c), 32'(alu_control), 32'd6);
      chk($sformatf("hold%0d in_ready", c), 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("hold release in_ready", 32'(in_ready), 32'd1);
    chk("hold release valid", 32'(out_valid), 32'd0);

    // MUL encoding on the SUPPORT_M=0 instance.
    @(negedge clk);
    drive(vt[14]);
    nm_in_valid = 1'b1;
    @(posedge clk);
    #1;
    nm_in_valid = 1'b0;
    chk("nm valid", 32'(nm_out_valid), 32'd1);
    chk("nm illegal", 32'(nm_illegal), 32'd1);
    chk("nm result", nm_result, 32'd0);
    chk("nm ctrl", 32'(nm_alu_control), 32'd15);
    @(negedge clk);
    nm_out_ready = 1'b1;
    @(posedge clk);
    #1;
    nm_out_ready = 1'b0;
    chk("nm in_ready", 32'(nm_in_ready), 32'd1);

    // Reset in the middle of a MUL aborts it.
    @(negedge clk);
    drive(vt[14]);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("abort state idle", 32'(in_ready), 32'd1);
    chk("abort valid", 32'(out_valid), 32'd0);
    chk("abort result", result, 32'd0);
    chk("abort ctrl", 32'(alu_control), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort no result", 32'(seen), 32'd0);

    run_vec(100, vt[2]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
